// File: rtl/audio_cfg_pkg.sv
// Shared definitions for the audio codec configuration path.
// Holds the I2C word width, the WM8731 slave address and register
// sub-addresses, and the state encoding of the I2C command arbiter.
package audio_cfg_pkg;

    localparam int I2C_WORD_W = 24;

    localparam logic [7:0] CODEC_ADDR = 8'h34;

    localparam logic [7:0] SUB_LIN_L  = 8'h00;
    localparam logic [7:0] SUB_RIN_R  = 8'h02;
    localparam logic [7:0] SUB_HEAD_L = 8'h04;
    localparam logic [7:0] SUB_HEAD_R = 8'h06;
    localparam logic [7:0] SUB_APATH  = 8'h08;
    localparam logic [7:0] SUB_DPATH  = 8'h0A;
    localparam logic [7:0] SUB_POWER  = 8'h0C;
    localparam logic [7:0] SUB_FORMAT = 8'h0E;
    localparam logic [7:0] SUB_SAMPLE = 8'h10;
    localparam logic [7:0] SUB_ACTIVE = 8'h12;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_ISSUE   = 2'd1,
        ARB_RELEASE = 2'd2,
        ARB_DECIDE  = 2'd3
    } arbState_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector.
// Picks the first set bit of iReqVec at or after iPtr, wrapping.
// Ports:
//   iReqVec    request vector
//   iPtr       search start index
//   oGrantIdx  index of the selected request
//   oValid     high when any request is set
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] iReqVec,
    input  logic [IDX_W-1:0]   iPtr,
    output logic [IDX_W-1:0]   oGrantIdx,
    output logic               oValid
);

    int cand;

    always_comb begin
        oGrantIdx = '0;
        oValid    = 1'b0;
        cand      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(iPtr) + i) % NUM_REQ;
            if (!oValid && iReqVec[cand]) begin
                oValid    = 1'b1;
                oGrantIdx = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// Shares one I2C_Controller among NUM_REQ requesters.
// Round-robin grant, latched word, GO/END/ACK handshake into the slow
// controller domain, NACK retry, per-phase timeout, done/error pulses.
//
// state       | meaning
// ARB_IDLE    | bus free, waiting for any request
// ARB_ISSUE   | GO high, waiting for synchronized END to rise
// ARB_RELEASE | GO low, waiting for END to fall (controller re-armed)
// ARB_DECIDE  | done/err pulse visible; return to IDLE or re-issue on NACK
//
// Ports:
//   iCLK, iRST_N   clock, async active-low reset
//   iREQ, iDATA    per-requester level request and 24-bit word
//   oDONE, oERR    per-requester one-cycle result pulses
//   oI2C_DATA, oI2C_GO, iI2C_END, iI2C_ACK   controller handshake
//   oBUSY, oGRANT  arbiter status
module i2c_cmd_arbiter
    import audio_cfg_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int DATA_W      = I2C_WORD_W,
    parameter int MAX_RETRY   = 3,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 262143
) (
    input  logic                        iCLK,
    input  logic                        iRST_N,
    input  logic [NUM_REQ-1:0]          iREQ,
    input  logic [NUM_REQ*DATA_W-1:0]   iDATA,
    output logic [NUM_REQ-1:0]          oDONE,
    output logic [NUM_REQ-1:0]          oERR,
    output logic [DATA_W-1:0]           oI2C_DATA,
    output logic                        oI2C_GO,
    input  logic                        iI2C_END,
    input  logic                        iI2C_ACK,
    output logic                        oBUSY,
    output logic [$clog2(NUM_REQ)-1:0]  oGRANT
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    arbState_t               state;
    logic [SYNC_STAGES-1:0]  endSync;
    logic [SYNC_STAGES-1:0]  ackSync;
    logic                    endS;
    logic                    ackS;
    logic                    ackHeld;
    logic [IDX_W-1:0]        rrPtr;
    logic [IDX_W-1:0]        nextPtr;
    logic [2:0]              retryCnt;
    logic [TO_W-1:0]         toCnt;
    logic [IDX_W-1:0]        reqIdx;
    logic                    reqValid;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            endSync <= '0;
            ackSync <= '0;
        end else begin
            endSync <= {endSync[SYNC_STAGES-2:0], iI2C_END};
            ackSync <= {ackSync[SYNC_STAGES-2:0], iI2C_ACK};
        end
    end

    assign endS = endSync[SYNC_STAGES-1];
    assign ackS = ackSync[SYNC_STAGES-1];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) uRrArbiter (
        .iReqVec   (iREQ),
        .iPtr      (rrPtr),
        .oGrantIdx (reqIdx),
        .oValid    (reqValid)
    );

    assign nextPtr = (int'(oGRANT) == NUM_REQ - 1) ? '0 : oGRANT + 1'b1;
    assign oBUSY   = (state != ARB_IDLE);

    // Result pulses are registered on the RELEASE->DECIDE edge so that
    // oDONE/oERR appear one cycle after the synchronized END falls; DECIDE
    // then reads back the pulse it is showing to pick IDLE or a retry.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state     <= ARB_IDLE;
            oDONE     <= '0;
            oERR      <= '0;
            oI2C_DATA <= '0;
            oI2C_GO   <= 1'b0;
            oGRANT    <= '0;
            rrPtr     <= '0;
            retryCnt  <= '0;
            toCnt     <= '0;
            ackHeld   <= 1'b0;
        end else begin
            oDONE <= '0;
            oERR  <= '0;
            case (state)
                ARB_IDLE: begin
                    if (reqValid) begin
                        oGRANT    <= reqIdx;
                        oI2C_DATA <= iDATA[int'(reqIdx)*DATA_W +: DATA_W];
                        toCnt     <= '0;
                        state     <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    if (toCnt == TO_LAST) begin
                        oI2C_GO      <= 1'b0;
                        oERR[oGRANT] <= 1'b1;
                        retryCnt     <= '0;
                        rrPtr        <= nextPtr;
                        state        <= ARB_IDLE;
                    end else if (endS) begin
                        ackHeld <= ackS;
                        oI2C_GO <= 1'b0;
                        toCnt   <= '0;
                        state   <= ARB_RELEASE;
                    end else begin
                        oI2C_GO <= 1'b1;
                        toCnt   <= toCnt + 1'b1;
                    end
                end
                ARB_RELEASE: begin
                    if (toCnt == TO_LAST) begin
                        oERR[oGRANT] <= 1'b1;
                        retryCnt     <= '0;
                        rrPtr        <= nextPtr;
                        state        <= ARB_IDLE;
                    end else if (!endS) begin
                        state <= ARB_DECIDE;
                        if (!ackHeld) begin
                            oDONE[oGRANT] <= 1'b1;
                            retryCnt      <= '0;
                            rrPtr         <= nextPtr;
                        end else if (int'(retryCnt) < MAX_RETRY) begin
                            retryCnt <= retryCnt + 1'b1;
                        end else begin
                            oERR[oGRANT] <= 1'b1;
                            retryCnt     <= '0;
                            rrPtr        <= nextPtr;
                        end
                    end else begin
                        toCnt <= toCnt + 1'b1;
                    end
                end
                ARB_DECIDE: begin
                    if ((oDONE | oERR) != '0) begin
                        state <= ARB_IDLE;
                    end else begin
                        toCnt <= '0;
                        state <= ARB_ISSUE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Self-checking bench for i2c_cmd_arbiter with a slow-clock I2C_Controller model.
module tb_i2c_cmd_arbiter;

    localparam int NR  = 2;
    localparam int DW  = 24;
    localparam int TOC = 1000;

    logic              iCLK;
    logic              iRST_N;
    logic [NR-1:0]     iREQ;
    logic [NR*DW-1:0]  iDATA;
    logic [NR-1:0]     oDONE;
    logic [NR-1:0]     oERR;
    logic [DW-1:0]     oI2C_DATA;
    logic              oI2C_GO;
    logic              iI2C_END;
    logic              iI2C_ACK;
    logic              oBUSY;
    logic [0:0]        oGRANT;

    logic ctlClk;

    typedef struct {
        int          idx;
        bit          isErr;
        logic [23:0] word;
    } exp_t;

    exp_t        expQ[$];
    bit          nackQ[$];
    logic [23:0] goWords[$];

    int nAssert = 0;
    int nFail   = 0;
    int goRises = 0;
    bit goPrev  = 0;
    bit modelOn = 1;
    int modelN;

    i2c_cmd_arbiter #(
        .NUM_REQ     (NR),
        .DATA_W      (DW),
        .MAX_RETRY   (3),
        .SYNC_STAGES (2),
        .TIMEOUT_CYC (TOC)
    ) dut (
        .iCLK      (iCLK),
        .iRST_N    (iRST_N),
        .iREQ      (iREQ),
        .iDATA     (iDATA),
        .oDONE     (oDONE),
        .oERR      (oERR),
        .oI2C_DATA (oI2C_DATA),
        .oI2C_GO   (oI2C_GO),
        .iI2C_END  (iI2C_END),
        .iI2C_ACK  (iI2C_ACK),
        .oBUSY     (oBUSY),
        .oGRANT    (oGRANT)
    );

    initial begin
        iCLK = 0;
        forever #5 iCLK = ~iCLK;
    end

    initial begin
        ctlClk = 0;
        #3;
        forever #20 ctlClk = ~ctlClk;
    end

    // Controller model: answers each GO after a slow-domain delay, with the
    // next queued ACK value (0 when the queue is empty).
    initial begin
        iI2C_END = 0;
        iI2C_ACK = 0;
        forever begin
            @(posedge ctlClk);
            if (modelOn && iRST_N && oI2C_GO && !iI2C_END) begin
                goWords.push_back(oI2C_DATA);
                repeat (2) @(posedge ctlClk);
                iI2C_ACK = (nackQ.size() > 0) ? nackQ.pop_front() : 1'b0;
                iI2C_END = 1;
                modelN = 0;
                while (oI2C_GO && modelN < 200) begin
                    @(posedge ctlClk);
                    modelN++;
                end
                @(posedge ctlClk);
                iI2C_END = 0;
            end
        end
    end

    always @(negedge iCLK) begin
        if (oI2C_GO && !goPrev) goRises++;
        goPrev = oI2C_GO;
        if (iRST_N && ((oDONE | oERR) != '0)) begin
            nAssert++;
            if ($countones(oDONE | oERR) != 1) begin
                nFail++;
                $display("FAIL onehot_result: done=%b err=%b, want exactly one bit", oDONE, oERR);
            end
        end
    end

    task automatic apply_reset();
        iRST_N = 0;
        repeat (3) @(negedge iCLK);
        iRST_N = 1;
        @(negedge iCLK);
    endtask

    task automatic wait_pulse(input int maxCyc, output logic [NR-1:0] d, output logic [NR-1:0] e,
                              output logic [23:0] w, output logic [0:0] g, output bit to);
        int n;
        n = 0;
        do begin
            @(negedge iCLK);
            n++;
        end while ((oDONE | oERR) == '0 && n < maxCyc);
        d  = oDONE;
        e  = oERR;
        w  = oI2C_DATA;
        g  = oGRANT;
        to = ((oDONE | oERR) == '0);
    endtask

    task automatic test_reset();
        iREQ  = '0;
        iDATA = '0;
        apply_reset();
        nAssert++;
        if (oI2C_GO !== 1'b0) begin nFail++; $display("FAIL reset_go: got %b want 0", oI2C_GO); end
        nAssert++;
        if (oBUSY !== 1'b0) begin nFail++; $display("FAIL reset_busy: got %b want 0", oBUSY); end
        nAssert++;
        if ((oDONE | oERR) !== '0) begin nFail++; $display("FAIL reset_pulses: done=%b err=%b want 0", oDONE, oERR); end
        nAssert++;
        if (oI2C_DATA !== '0 || oGRANT !== '0) begin
            nFail++; $display("FAIL reset_data_grant: data=%h grant=%0d want 0", oI2C_DATA, oGRANT);
        end
    endtask

    task automatic test_single();
        logic [NR-1:0] d, e;
        logic [23:0]   w;
        logic [0:0]    g;
        bit            to;
        int            n, rises0;
        exp_t          ex;
        rises0 = goRises;
        goWords.delete();
        iDATA[0*DW +: DW] = 24'h34_1201;
        iDATA[1*DW +: DW] = 24'h34_0E42;
        @(negedge iCLK);
        iREQ = 2'b01;
        expQ.push_back('{0, 1'b0, 24'h341201});
        n = 0;
        while (!oI2C_GO && n < 10) begin @(negedge iCLK); n++; end
        nAssert++;
        if (n != 2) begin nFail++; $display("FAIL single_latency: got %0d cycles want 2", n); end
        nAssert++;
        if (oI2C_DATA !== 24'h341201) begin nFail++; $display("FAIL single_word: got %h want 341201", oI2C_DATA); end
        wait_pulse(500, d, e, w, g, to);
        iREQ = '0;
        ex = expQ.pop_front();
        nAssert++;
        if (to || d !== (NR'(1) << ex.idx) || e !== '0 || w !== ex.word) begin
            nFail++; $display("FAIL single_done: done=%b err=%b word=%h to=%0d want done idx %0d word %h", d, e, w, to, ex.idx, ex.word);
        end
        nAssert++;
        if (goRises - rises0 != 1 || goWords.size() != 1) begin
            nFail++; $display("FAIL single_go_count: rises=%0d seen=%0d want 1", goRises - rises0, goWords.size());
        end
        repeat (3) @(negedge iCLK);
        nAssert++;
        if (oBUSY !== 1'b0) begin nFail++; $display("FAIL single_idle: busy=%b want 0", oBUSY); end
    endtask

    task automatic test_contention();
        logic [NR-1:0] d, e;
        logic [23:0]   w;
        logic [0:0]    g;
        bit            to;
        exp_t          ex;
        apply_reset();
        iDATA[0*DW +: DW] = 24'h34_0C00;
        iDATA[1*DW +: DW] = 24'h34_0417;
        for (int k = 0; k < 4; k++)
            expQ.push_back('{k % 2, 1'b0, (k % 2 == 0) ? 24'h340C00 : 24'h340417});
        iREQ = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_pulse(500, d, e, w, g, to);
            if (k == 3) iREQ = '0;
            ex = expQ.pop_front();
            nAssert++;
            if (to || d !== (NR'(1) << ex.idx) || e !== '0 || w !== ex.word || int'(g) != ex.idx) begin
                nFail++; $display("FAIL contention_%0d: done=%b err=%b word=%h grant=%0d to=%0d want idx %0d word %h", k, d, e, w, g, to, ex.idx, ex.word);
            end
        end
        repeat (20) @(negedge iCLK);
        nAssert++;
        if (oBUSY !== 1'b0 || goRises == 0) begin nFail++; $display("FAIL contention_idle: busy=%b want 0", oBUSY); end
    endtask

    task automatic test_nack_retry();
        logic [NR-1:0] d, e;
        logic [23:0]   w;
        logic [0:0]    g;
        bit            to;
        int            rises0;
        bit            same;
        exp_t          ex;
        rises0 = goRises;
        goWords.delete();
        nackQ.push_back(1'b1);
        nackQ.push_back(1'b1);
        iDATA[1*DW +: DW] = 24'h34_0879;
        expQ.push_back('{1, 1'b0, 24'h340879});
        iREQ = 2'b10;
        wait_pulse(1000, d, e, w, g, to);
        iREQ = '0;
        ex = expQ.pop_front();
        nAssert++;
        if (to || d !== (NR'(1) << ex.idx) || e !== '0 || w !== ex.word) begin
            nFail++; $display("FAIL nack_done: done=%b err=%b word=%h to=%0d want done idx %0d", d, e, w, to, ex.idx);
        end
        same = 1;
        foreach (goWords[i]) if (goWords[i] !== 24'h340879) same = 0;
        nAssert++;
        if (goRises - rises0 != 3 || goWords.size() != 3 || !same) begin
            nFail++; $display("FAIL nack_go_count: rises=%0d seen=%0d sameword=%0d want 3 3 1", goRises - rises0, goWords.size(), same);
        end
    endtask

    task automatic test_retry_exhausted();
        logic [NR-1:0] d, e;
        logic [23:0]   w;
        logic [0:0]    g;
        bit            to;
        int            rises0;
        exp_t          ex;
        rises0 = goRises;
        nackQ.delete();
        repeat (4) nackQ.push_back(1'b1);
        iDATA[0*DW +: DW] = 24'h34_1001;
        iDATA[1*DW +: DW] = 24'h34_0A06;
        expQ.push_back('{0, 1'b1, 24'h341001});
        expQ.push_back('{1, 1'b0, 24'h340A06});
        iREQ = 2'b11;
        wait_pulse(2000, d, e, w, g, to);
        iREQ[0] = 1'b0;
        ex = expQ.pop_front();
        nAssert++;
        if (to || e !== (NR'(1) << ex.idx) || d !== '0 || w !== ex.word) begin
            nFail++; $display("FAIL exhausted_err: done=%b err=%b word=%h to=%0d want err idx %0d", d, e, w, to, ex.idx);
        end
        nAssert++;
        if (goRises - rises0 != 4) begin nFail++; $display("FAIL exhausted_go_count: got %0d want 4", goRises - rises0); end
        wait_pulse(1000, d, e, w, g, to);
        iREQ = '0;
        ex = expQ.pop_front();
        nAssert++;
        if (to || d !== (NR'(1) << ex.idx) || e !== '0 || w !== ex.word) begin
            nFail++; $display("FAIL exhausted_next: done=%b err=%b word=%h to=%0d want done idx %0d", d, e, w, to, ex.idx);
        end
    endtask

    task automatic test_timeout();
        int   n, goHigh;
        exp_t ex;
        logic [NR-1:0] d, e;
        repeat (5) @(negedge iCLK);
        modelOn = 0;
        iDATA[0*DW +: DW] = 24'h34_1200;
        expQ.push_back('{0, 1'b1, 24'h341200});
        iREQ = 2'b01;
        n = 0;
        goHigh = 0;
        while ((oDONE | oERR) == '0 && n < 3000) begin
            @(negedge iCLK);
            n++;
            if (oI2C_GO) goHigh++;
        end
        d = oDONE;
        e = oERR;
        iREQ = '0;
        ex = expQ.pop_front();
        nAssert++;
        if (e !== (NR'(1) << ex.idx) || d !== '0) begin
            nFail++; $display("FAIL timeout_err: done=%b err=%b cycles=%0d want err idx %0d", d, e, n, ex.idx);
        end
        nAssert++;
        if (goHigh < TOC - 2 || goHigh > TOC || oI2C_GO !== 1'b0) begin
            nFail++; $display("FAIL timeout_go: high %0d cycles go=%b want %0d..%0d and 0", goHigh, oI2C_GO, TOC - 2, TOC);
        end
        @(negedge iCLK);
        nAssert++;
        if (oBUSY !== 1'b0) begin nFail++; $display("FAIL timeout_busy: got %b want 0", oBUSY); end
    endtask

    task automatic test_reset_mid();
        logic [NR-1:0] d, e;
        logic [23:0]   w;
        logic [0:0]    g;
        bit            to;
        int            n;
        exp_t          ex;
        iDATA[1*DW +: DW] = 24'h34_0697;
        iREQ = 2'b10;
        n = 0;
        while (!oI2C_GO && n < 20) begin @(negedge iCLK); n++; end
        nAssert++;
        if (oI2C_GO !== 1'b1 || oGRANT !== 1'b1) begin nFail++; $display("FAIL rstmid_pre: go=%b grant=%0d want 1 1", oI2C_GO, oGRANT); end
        #2;
        iRST_N = 0;
        #1;
        nAssert++;
        if (oI2C_GO !== 1'b0 || oBUSY !== 1'b0 || oGRANT !== 1'b0) begin
            nFail++; $display("FAIL rstmid_async: go=%b busy=%b grant=%0d want 0 0 0", oI2C_GO, oBUSY, oGRANT);
        end
        repeat (2) @(negedge iCLK);
        modelOn = 1;
        iDATA[0*DW +: DW] = 24'h34_0E0A;
        expQ.push_back('{0, 1'b0, 24'h340E0A});
        expQ.push_back('{1, 1'b0, 24'h340697});
        iREQ = 2'b11;
        iRST_N = 1;
        for (int k = 0; k < 2; k++) begin
            wait_pulse(1000, d, e, w, g, to);
            iREQ[k] = 1'b0;
            ex = expQ.pop_front();
            nAssert++;
            if (to || d !== (NR'(1) << ex.idx) || e !== '0 || w !== ex.word) begin
                nFail++; $display("FAIL rstmid_after_%0d: done=%b err=%b word=%h to=%0d want done idx %0d word %h", k, d, e, w, to, ex.idx, ex.word);
            end
        end
    endtask

    initial begin
        iRST_N = 0;
        iREQ   = '0;
        iDATA  = '0;
        test_reset();
        test_single();
        test_contention();
        test_nack_retry();
        test_retry_exhausted();
        test_timeout();
        test_reset_mid();
        repeat (5) @(negedge iCLK);
        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
